// File: rtl/featuremap_channel_packer_pkg.sv
// featuremap_channel_packer_pkg: shared layer constants and packer state encoding
package featuremap_channel_packer_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int LAYER4_NUM_CHANNELS = 32;
    localparam int LAYER4_IMG_SIZE = 104;
    typedef enum logic {IDLE = 1'b0, PACK = 1'b1} state_t;
endpackage

// File: rtl/featuremap_channel_packer.sv
// featuremap_channel_packer: packs a channel-serial fp32 stream into one wide pixel word per NUM_CHANNELS transfers
module featuremap_channel_packer #(
    parameter int DATA_WIDTH = featuremap_channel_packer_pkg::DATA_WIDTH,
    parameter int NUM_CHANNELS = featuremap_channel_packer_pkg::LAYER4_NUM_CHANNELS,
    parameter int IMG_SIZE = featuremap_channel_packer_pkg::LAYER4_IMG_SIZE
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               start,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               valid_in,
    output logic                               ready_out,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0] data_out,
    output logic                               valid_out,
    output logic                               busy,
    output logic                               frame_done
);
    import featuremap_channel_packer_pkg::*;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int NPIX = IMG_SIZE * IMG_SIZE;
    localparam int PW = NPIX > 1 ? $clog2(NPIX) : 1;
    state_t state;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] pack, pack_next;
    logic [CW-1:0] ch_cnt;
    logic [PW-1:0] pix_cnt;
    logic xfer, last_ch, last_pix;
    assign xfer = valid_in && ready_out;
    assign last_ch = ch_cnt == CW'(NUM_CHANNELS - 1);
    assign last_pix = pix_cnt == PW'(NPIX - 1);
    assign busy = ready_out;
    // The completed pixel is taken from pack_next so the last word lands in data_out on the same edge
    always_comb begin
        pack_next = pack;
        pack_next[ch_cnt] = data_in;
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            pack <= '0;
            data_out <= '0;
            ch_cnt <= '0;
            pix_cnt <= '0;
            ready_out <= 1'b0;
            valid_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out <= xfer && last_ch;
            frame_done <= xfer && last_ch && last_pix;
            if (state == IDLE) begin
                if (start) begin
                    state <= PACK;
                    ready_out <= 1'b1;
                    ch_cnt <= '0;
                    pix_cnt <= '0;
                end
            end else if (xfer) begin
                pack <= pack_next;
                ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
                if (last_ch) begin
                    data_out <= pack_next;
                    pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
                    if (last_pix) begin
                        state <= IDLE;
                        ready_out <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_featuremap_channel_packer.sv
// tb_featuremap_channel_packer: directed checks on three packer configurations sharing one stimulus bus
module tb_featuremap_channel_packer;
    logic clk, rst_n, start, valid_in;
    logic [31:0] data_in;
    logic a_ready, a_valid, a_busy, a_done;
    logic [127:0] a_data;
    logic b_ready, b_valid, b_busy, b_done;
    logic [127:0] b_data;
    logic c_ready, c_valid, c_busy, c_done;
    logic [1023:0] c_data;
    int checks = 0;
    int errors = 0;

    featuremap_channel_packer #(.DATA_WIDTH(32), .NUM_CHANNELS(4), .IMG_SIZE(2)) u_a (
        .Clk(clk), .Rst(rst_n), .start(start), .data_in(data_in), .valid_in(valid_in),
        .ready_out(a_ready), .data_out(a_data), .valid_out(a_valid), .busy(a_busy), .frame_done(a_done));
    featuremap_channel_packer #(.DATA_WIDTH(32), .NUM_CHANNELS(4), .IMG_SIZE(1)) u_b (
        .Clk(clk), .Rst(rst_n), .start(start), .data_in(data_in), .valid_in(valid_in),
        .ready_out(b_ready), .data_out(b_data), .valid_out(b_valid), .busy(b_busy), .frame_done(b_done));
    featuremap_channel_packer u_c (
        .Clk(clk), .Rst(rst_n), .start(start), .data_in(data_in), .valid_in(valid_in),
        .ready_out(c_ready), .data_out(c_data), .valid_out(c_valid), .busy(c_busy), .frame_done(c_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic st;
        logic vi;
        logic [31:0] d;
        logic e_rdy;
        logic e_vo;
        logic e_fd;
        logic [127:0] e_do;
    } vec_t;
    vec_t tv[18];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic vi, input logic [31:0] d);
        start = st;
        valid_in = vi;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] w(input int k);
        return 32'h100 + k;
    endfunction

    initial begin
        int acc, pulses, dones;
        logic vi;
        rst_n = 1'b0;
        start = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_data", a_data, 0);
        rst_n = 1'b1;
        // valid_in while idle must be dropped
        pulses = 0;
        repeat (3) begin
            cyc(0, 1, 32'h3f800000);
            if (a_valid || b_valid || c_valid) pulses++;
        end
        chk("idle_no_valid", 128'(pulses), 0);
        chk("idle_ready", a_ready, 0);
        chk("idle_data_a", a_data, 0);
        chk("idle_data_c", c_data[127:0], 0);

        // single pixel, single-pixel frame
        do_reset();
        cyc(1, 0, 0);
        chk("single_ready", b_ready, 1);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 32'(i));
        chk("single_valid", b_valid, 1);
        chk("single_done", b_done, 1);
        chk("single_data", b_data, 128'h00000004_00000003_00000002_00000001);
        cyc(0, 0, 0);
        chk("single_ready_after", b_ready, 0);
        chk("single_busy_after", b_busy, 0);
        chk("single_valid_after", b_valid, 0);
        chk("single_data_hold", b_data, 128'h00000004_00000003_00000002_00000001);

        // stalling input on the default 32-channel configuration
        do_reset();
        cyc(1, 0, 0);
        acc = 0;
        pulses = 0;
        for (int t = 0; t < 70; t++) begin
            vi = (t % 2 == 0) && (acc < 32);
            cyc(0, vi, 32'hA000 + acc);
            if (vi) acc++;
            if (c_valid) begin
                pulses++;
                chk("stall_pulse_time", 128'({vi, 6'(acc)}), 128'({1'b1, 6'd32}));
            end
        end
        chk("stall_pulses", 128'(pulses), 1);
        chk("stall_slot31", c_data[31*32 +: 32], 32'hA000 + 31);
        chk("stall_slot0", c_data[31:0], 32'hA000);
        chk("stall_busy", c_busy, 1);
        chk("stall_no_done", c_done, 0);

        // back-to-back pixels across a 2x2 frame, followed by an ignored idle word
        tv[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 128'h0};
        for (int k = 1; k <= 16; k++) begin
            int b;
            b = (k / 4) * 4;
            tv[k] = '{1'b0, 1'b1, w(k), k < 16, k % 4 == 0, k == 16,
                      b == 0 ? 128'h0 : {w(b), w(b-1), w(b-2), w(b-3)}};
        end
        tv[17] = '{1'b0, 1'b1, 32'hdead, 1'b0, 1'b0, 1'b0, {w(16), w(15), w(14), w(13)}};
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(tv[i].st, tv[i].vi, tv[i].d);
            chk($sformatf("b2b_ready[%0d]", i), a_ready, tv[i].e_rdy);
            chk($sformatf("b2b_busy[%0d]", i), a_busy, tv[i].e_rdy);
            chk($sformatf("b2b_valid[%0d]", i), a_valid, tv[i].e_vo);
            chk($sformatf("b2b_done[%0d]", i), a_done, tv[i].e_fd);
            chk($sformatf("b2b_data[%0d]", i), a_data, tv[i].e_do);
        end

        // asynchronous reset mid-pixel discards the partial pixel
        cyc(1, 0, 0);
        cyc(0, 1, 32'h11);
        cyc(0, 1, 32'h22);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", a_data, 0);
        chk("async_rst_ready", a_ready, 0);
        chk("async_rst_busy", a_busy, 0);
        chk("async_rst_valid", a_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready", a_ready, 0);
        cyc(1, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            cyc(0, i <= 4, 32'h30 + i);
            if (a_valid) pulses++;
        end
        chk("rst_pixel_pulses", 128'(pulses), 1);
        chk("rst_pixel_data", a_data, 128'h00000034_00000033_00000032_00000031);

        // start during PACK (and on the final transfer) is ignored
        do_reset();
        cyc(1, 0, 0);
        pulses = 0;
        dones = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc(k == 5 || k == 6 || k == 16, 1, w(k));
            if (a_valid) pulses++;
            if (a_done) begin
                dones++;
                chk("ign_done_at_last", 128'(k), 16);
            end
        end
        chk("ign_pulses", 128'(pulses), 4);
        chk("ign_dones", 128'(dones), 1);
        chk("ign_busy_end", a_busy, 0);
        cyc(0, 0, 0);
        chk("ign_final_start", a_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
